// File: rtl/pa_sysmap_pkg.sv
// Shared definitions for the sysmap TCIP request bridge.
//   - FSM state encoding used by pa_sysmap_tcipif_req
//   - sysmap register count, default address limit and register byte offsets
//   - sysmap_addr_ok(): alignment/range screen applied to incoming requests
package pa_sysmap_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StReq  = 2'b01,
        StResp = 2'b10
    } sysmap_state_e;

    localparam int unsigned SYSMAP_REG_NUM            = 16;
    localparam logic [15:0] SYSMAP_ADDR_LIMIT_DEFAULT = 16'h0040;

    // Registers come in ADDRn/ATTRn pairs: ADDRn at 8n, ATTRn at 8n+4.
    localparam logic [15:0] SYSMAP_ADDR0 = 16'h0000;
    localparam logic [15:0] SYSMAP_ATTR0 = 16'h0004;
    localparam logic [15:0] SYSMAP_ADDR1 = 16'h0008;
    localparam logic [15:0] SYSMAP_ATTR1 = 16'h000C;
    localparam logic [15:0] SYSMAP_ADDR2 = 16'h0010;
    localparam logic [15:0] SYSMAP_ATTR2 = 16'h0014;
    localparam logic [15:0] SYSMAP_ADDR3 = 16'h0018;
    localparam logic [15:0] SYSMAP_ATTR3 = 16'h001C;
    localparam logic [15:0] SYSMAP_ADDR4 = 16'h0020;
    localparam logic [15:0] SYSMAP_ATTR4 = 16'h0024;
    localparam logic [15:0] SYSMAP_ADDR5 = 16'h0028;
    localparam logic [15:0] SYSMAP_ATTR5 = 16'h002C;
    localparam logic [15:0] SYSMAP_ADDR6 = 16'h0030;
    localparam logic [15:0] SYSMAP_ATTR6 = 16'h0034;
    localparam logic [15:0] SYSMAP_ADDR7 = 16'h0038;
    localparam logic [15:0] SYSMAP_ATTR7 = 16'h003C;

    // A request may reach the sysmap only if word aligned and below the limit.
    function automatic logic sysmap_addr_ok(input logic [15:0] addr, input logic [15:0] limit);
        return (addr[1:0] == 2'b00) && (addr < limit);
    endfunction

endpackage

// File: rtl/pa_sysmap_tcipif_tmo_cnt.sv
// Timeout counter for the sysmap request bridge.
//   clk_i     clock
//   rst_i     synchronous active-high reset
//   clr_i     clear the count to zero (takes priority over inc_i)
//   inc_i     increment the count
//   expire_o  count has reached TIMEOUT-1
module pa_sysmap_tcipif_tmo_cnt #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic expire_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (inc_i) begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign expire_o = (cnt_q == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/pa_sysmap_tcipif_req.sv
// Request-side bridge between the TCIP decoder and the sysmap register block.
// Accepts one access at a time, rejects misaligned/out-of-range offsets without
// touching the sysmap, otherwise drives select until completion or timeout, then
// presents rdata/err on the response channel until accepted.
//   forever_cpuclk / cpurst          clock, synchronous active-high reset
//   tcipif_req_*                      request channel (valid/ready, addr, write, wdata)
//   tcipif_rsp_*                      response channel (valid/ready, rdata, err)
//   tcipif_sysmap_*                   select/addr/write/wdata towards the sysmap
//   sysmap_tcipif_cmplt / _rdata      completion and read data from the sysmap
module pa_sysmap_tcipif_req
    import pa_sysmap_pkg::*;
#(
    parameter int unsigned TIMEOUT    = 16,
    parameter logic [15:0] ADDR_LIMIT = SYSMAP_ADDR_LIMIT_DEFAULT
) (
    input  logic        forever_cpuclk,
    input  logic        cpurst,
    input  logic        tcipif_req_vld,
    output logic        tcipif_req_rdy,
    input  logic [15:0] tcipif_req_addr,
    input  logic        tcipif_req_write,
    input  logic [31:0] tcipif_req_wdata,
    output logic        tcipif_rsp_vld,
    input  logic        tcipif_rsp_rdy,
    output logic [31:0] tcipif_rsp_rdata,
    output logic        tcipif_rsp_err,
    output logic        tcipif_sysmap_sel,
    output logic [15:0] tcipif_sysmap_addr,
    output logic        tcipif_sysmap_write,
    output logic [31:0] tcipif_sysmap_wdata,
    input  logic        sysmap_tcipif_cmplt,
    input  logic [31:0] sysmap_tcipif_rdata
);

    sysmap_state_e state_q;
    logic          req_rdy_q;
    logic          rsp_vld_q;
    logic          rsp_err_q;
    logic [31:0]   rsp_rdata_q;
    logic          sel_q;
    logic [15:0]   addr_q;
    logic          write_q;
    logic [31:0]   wdata_q;

    logic tmo_clr;
    logic tmo_inc;
    logic tmo_expire;

    // Clearing on every accept is harmless for rejected requests and keeps it simple.
    assign tmo_clr = (state_q == StIdle) && tcipif_req_vld;
    assign tmo_inc = (state_q == StReq) && !sysmap_tcipif_cmplt && !tmo_expire;

    pa_sysmap_tcipif_tmo_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo_cnt (
        .clk_i    (forever_cpuclk),
        .rst_i    (cpurst),
        .clr_i    (tmo_clr),
        .inc_i    (tmo_inc),
        .expire_o (tmo_expire)
    );

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state_q     <= StIdle;
            req_rdy_q   <= 1'b1;
            rsp_vld_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            sel_q       <= 1'b0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (tcipif_req_vld) begin
                        addr_q    <= tcipif_req_addr;
                        write_q   <= tcipif_req_write;
                        wdata_q   <= tcipif_req_wdata;
                        req_rdy_q <= 1'b0;
                        if (sysmap_addr_ok(tcipif_req_addr, ADDR_LIMIT)) begin
                            state_q <= StReq;
                            sel_q   <= 1'b1;
                        end else begin
                            state_q     <= StResp;
                            rsp_vld_q   <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end
                    end
                end
                StReq: begin
                    // Completion is checked first so it wins in the timeout cycle.
                    if (sysmap_tcipif_cmplt) begin
                        state_q     <= StResp;
                        sel_q       <= 1'b0;
                        rsp_vld_q   <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= write_q ? '0 : sysmap_tcipif_rdata;
                    end else if (tmo_expire) begin
                        state_q     <= StResp;
                        sel_q       <= 1'b0;
                        rsp_vld_q   <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                    end
                end
                StResp: begin
                    if (tcipif_rsp_rdy) begin
                        state_q   <= StIdle;
                        rsp_vld_q <= 1'b0;
                        req_rdy_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign tcipif_req_rdy      = req_rdy_q;
    assign tcipif_rsp_vld      = rsp_vld_q;
    assign tcipif_rsp_err      = rsp_err_q;
    assign tcipif_rsp_rdata    = rsp_rdata_q;
    assign tcipif_sysmap_sel   = sel_q;
    assign tcipif_sysmap_addr  = addr_q;
    assign tcipif_sysmap_write = write_q;
    assign tcipif_sysmap_wdata = wdata_q;

endmodule

// File: tb/tb_pa_sysmap_tcipif_req.sv
// Self-checking bench for pa_sysmap_tcipif_req: directed scenarios followed by
// randomized transactions, each predicted from the access rules (alignment,
// range, completion cycle versus timeout) rather than from the RTL structure.
module tb_pa_sysmap_tcipif_req;

    localparam int          TIMEOUT    = 16;
    localparam logic [15:0] ADDR_LIMIT = 16'h0040;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_vld = 1'b0;
    logic        req_rdy;
    logic [15:0] req_addr = '0;
    logic        req_write = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        rsp_vld;
    logic        rsp_rdy = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        sm_sel;
    logic [15:0] sm_addr;
    logic        sm_write;
    logic [31:0] sm_wdata;
    logic        sm_cmplt = 1'b0;
    logic [31:0] sm_rdata = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pa_sysmap_tcipif_req #(
        .TIMEOUT    (TIMEOUT),
        .ADDR_LIMIT (ADDR_LIMIT)
    ) dut (
        .forever_cpuclk      (clk),
        .cpurst              (rst),
        .tcipif_req_vld      (req_vld),
        .tcipif_req_rdy      (req_rdy),
        .tcipif_req_addr     (req_addr),
        .tcipif_req_write    (req_write),
        .tcipif_req_wdata    (req_wdata),
        .tcipif_rsp_vld      (rsp_vld),
        .tcipif_rsp_rdy      (rsp_rdy),
        .tcipif_rsp_rdata    (rsp_rdata),
        .tcipif_rsp_err      (rsp_err),
        .tcipif_sysmap_sel   (sm_sel),
        .tcipif_sysmap_addr  (sm_addr),
        .tcipif_sysmap_write (sm_write),
        .tcipif_sysmap_wdata (sm_wdata),
        .sysmap_tcipif_cmplt (sm_cmplt),
        .sysmap_tcipif_rdata (sm_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One access from the idle state. cmplt_at is the select cycle (1-based) in
    // which the sysmap completes; 0 or anything past TIMEOUT means never.
    // All sampling and driving happens on the falling edge.
    task automatic run_txn(input logic [15:0] a, input logic w, input logic [31:0] wd,
                           input int cmplt_at, input logic [31:0] srd, input int hold,
                           input bit stray);
        int          exp_lat;
        int          exp_sel;
        logic        exp_err;
        logic [31:0] exp_rd;
        int          lat;
        int          sel_n;
        int          unstable;
        int          cyc;

        // Reference: what the access rules say should happen.
        if (a[1:0] != 2'b00 || a >= ADDR_LIMIT) begin
            exp_lat = 1; exp_sel = 0; exp_err = 1'b1; exp_rd = 32'h0;
        end else if (cmplt_at >= 1 && cmplt_at <= TIMEOUT) begin
            exp_lat = cmplt_at + 1; exp_sel = cmplt_at; exp_err = 1'b0;
            exp_rd  = w ? 32'h0 : srd;
        end else begin
            exp_lat = TIMEOUT + 1; exp_sel = TIMEOUT; exp_err = 1'b1; exp_rd = 32'h0;
        end

        chk("idle_req_rdy", 32'(req_rdy), 32'(1));
        chk("idle_rsp_vld", 32'(rsp_vld), 32'(0));
        req_vld = 1'b1; req_addr = a; req_write = w; req_wdata = wd;
        @(negedge clk);

        lat = 0; sel_n = 0; unstable = 0; cyc = 1;
        while (cyc <= TIMEOUT + 4 && lat == 0) begin
            if (rsp_vld) begin
                lat = cyc;
            end else begin
                if (sm_sel) begin
                    sel_n++;
                    if (sm_addr !== a || sm_write !== w || sm_wdata !== wd) unstable++;
                end
                sm_cmplt  = (cmplt_at == cyc);
                sm_rdata  = sm_cmplt ? srd : $urandom;
                // Request side is don't-care while busy; toss garbage at it.
                req_vld   = 1'($urandom_range(0, 1));
                req_addr  = 16'($urandom);
                req_write = 1'($urandom_range(0, 1));
                req_wdata = $urandom;
                @(negedge clk);
                cyc++;
            end
        end
        sm_cmplt = 1'b0; req_vld = 1'b0;

        chk("rsp_latency", 32'(lat), 32'(exp_lat));
        chk("sel_cycles", 32'(sel_n), 32'(exp_sel));
        chk("sysmap_stable", 32'(unstable), 32'(0));
        chk("latched_addr", 32'(sm_addr), 32'(a));
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
        chk("rsp_sel_low", 32'(sm_sel), 32'(0));
        chk("rsp_req_rdy", 32'(req_rdy), 32'(0));

        for (int h = 0; h < hold; h++) begin
            sm_cmplt = stray ? 1'($urandom_range(0, 1)) : 1'b0;
            sm_rdata = $urandom;
            @(negedge clk);
            chk("hold_rsp_vld", 32'(rsp_vld), 32'(1));
            chk("hold_rdata", rsp_rdata, exp_rd);
            chk("hold_err", 32'(rsp_err), 32'(exp_err));
            chk("hold_req_rdy", 32'(req_rdy), 32'(0));
            chk("hold_sel", 32'(sm_sel), 32'(0));
        end
        sm_cmplt = 1'b0;
        rsp_rdy  = 1'b1;
        @(negedge clk);
        rsp_rdy = 1'b0;
        chk("post_rsp_vld", 32'(rsp_vld), 32'(0));
        chk("post_req_rdy", 32'(req_rdy), 32'(1));
    endtask

    initial begin
        int stray_seen;

        // Reset values.
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_rdy", 32'(req_rdy), 32'(1));
        chk("rst_rsp_vld", 32'(rsp_vld), 32'(0));
        chk("rst_rsp_err", 32'(rsp_err), 32'(0));
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_sel", 32'(sm_sel), 32'(0));
        chk("rst_sm_addr", 32'(sm_addr), 32'h0);
        chk("rst_sm_write", 32'(sm_write), 32'(0));
        chk("rst_sm_wdata", sm_wdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Directed scenarios.
        run_txn(16'h0008, 1'b0, 32'h0, 1, 32'h000F_0000, 0, 1'b0);
        run_txn(16'h0010, 1'b1, 32'h1234_5000, 3, 32'hDEAD_BEEF, 0, 1'b0);
        run_txn(16'h0006, 1'b0, 32'h0, 1, 32'h1111_1111, 0, 1'b0);
        run_txn(16'h0040, 1'b0, 32'h0, 1, 32'h2222_2222, 0, 1'b0);
        run_txn(16'h000C, 1'b0, 32'h0, 0, 32'h3333_3333, 0, 1'b0);
        run_txn(16'h000C, 1'b0, 32'h0, TIMEOUT, 32'h4444_4444, 0, 1'b0);
        run_txn(16'h003C, 1'b0, 32'h0, 2, 32'h5555_AAAA, 5, 1'b1);

        // Reset in the second select cycle abandons the access.
        req_vld = 1'b1; req_addr = 16'h0020; req_write = 1'b0;
        @(negedge clk);
        req_vld = 1'b0;
        chk("rstreq_sel_c1", 32'(sm_sel), 32'(1));
        @(negedge clk);
        chk("rstreq_sel_c2", 32'(sm_sel), 32'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstreq_sel", 32'(sm_sel), 32'(0));
        chk("rstreq_rsp_vld", 32'(rsp_vld), 32'(0));
        chk("rstreq_req_rdy", 32'(req_rdy), 32'(1));
        stray_seen = 0;
        for (int i = 0; i < 20; i++) begin
            sm_cmplt = 1'($urandom_range(0, 1));
            sm_rdata = $urandom;
            @(negedge clk);
            if (rsp_vld || sm_sel || !req_rdy) stray_seen++;
        end
        sm_cmplt = 1'b0;
        chk("rstreq_quiet", 32'(stray_seen), 32'(0));

        // Randomized accesses.
        for (int n = 0; n < 40; n++) begin
            logic [15:0] a;
            if ($urandom_range(0, 3) == 0) a = 16'($urandom_range(0, 16'h4F));
            else                           a = 16'($urandom_range(0, 16'h4F)) & 16'hFFFC;
            run_txn(a, 1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, TIMEOUT + 2)),
                    $urandom, int'($urandom_range(0, 3)), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, observed running expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule
